// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush handshake bundle between the core datapath (master) and the pipeline sequencer (slave).
// PIPE_STALL_PERF_EN adds the three 32-bit stall-cycle counters to the bundle.
interface pipe_stall_ctrl_if;
   logic        ID_EX_DH_Stall;
   logic        ID_MEM1_DH_Stall;
   logic        ID_MEM2_DH_Stall;
   logic        Icache_Busy;
   logic        Dcache_Busy;
   logic        EXE_DivStart;
   logic        EXE_PredFail;
   logic        MEM_Exception;

   logic        PC_Wr;
   logic        ID_Wr;
   logic        EXE_Wr;
   logic        MEM_Wr;
   logic        MEM2_Wr;
   logic        WB_Wr;
   logic        ID_Flush;
   logic        EXE_Flush;
   logic        MEM_Flush;
   logic        MEM2_Flush;
   logic        Div_Done;
   logic        Div_Abort;
   logic        Exc_Redirect;

`ifdef PIPE_STALL_PERF_EN
   logic [31:0] Perf_DH_Cycles;
   logic [31:0] Perf_Dc_Cycles;
   logic [31:0] Perf_Div_Cycles;

   modport master (
      output ID_EX_DH_Stall, ID_MEM1_DH_Stall, ID_MEM2_DH_Stall,
      output Icache_Busy, Dcache_Busy, EXE_DivStart, EXE_PredFail, MEM_Exception,
      input  PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr,
      input  ID_Flush, EXE_Flush, MEM_Flush, MEM2_Flush,
      input  Div_Done, Div_Abort, Exc_Redirect,
      input  Perf_DH_Cycles, Perf_Dc_Cycles, Perf_Div_Cycles
   );

   modport slave (
      input  ID_EX_DH_Stall, ID_MEM1_DH_Stall, ID_MEM2_DH_Stall,
      input  Icache_Busy, Dcache_Busy, EXE_DivStart, EXE_PredFail, MEM_Exception,
      output PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr,
      output ID_Flush, EXE_Flush, MEM_Flush, MEM2_Flush,
      output Div_Done, Div_Abort, Exc_Redirect,
      output Perf_DH_Cycles, Perf_Dc_Cycles, Perf_Div_Cycles
   );
`else
   modport master (
      output ID_EX_DH_Stall, ID_MEM1_DH_Stall, ID_MEM2_DH_Stall,
      output Icache_Busy, Dcache_Busy, EXE_DivStart, EXE_PredFail, MEM_Exception,
      input  PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr,
      input  ID_Flush, EXE_Flush, MEM_Flush, MEM2_Flush,
      input  Div_Done, Div_Abort, Exc_Redirect
   );

   modport slave (
      input  ID_EX_DH_Stall, ID_MEM1_DH_Stall, ID_MEM2_DH_Stall,
      input  Icache_Busy, Dcache_Busy, EXE_DivStart, EXE_PredFail, MEM_Exception,
      output PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr,
      output ID_Flush, EXE_Flush, MEM_Flush, MEM2_Flush,
      output Div_Done, Div_Abort, Exc_Redirect
   );
`endif
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges hazards, cache busy, divide hold and exceptions into per-stage enables/flushes, zero-latency (combinational) outputs.
// Optional PIPE_STALL_PERF_EN adds wrapping 32-bit counters of DH, D-cache and divide stall cycles.
module pipe_stall_ctrl #(
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic              clk,
   input  logic              resetn,
   pipe_stall_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_RUN = 2'd0,
      S_DIV = 2'd1,
      S_EXC = 2'd2
   } state_t;

   // The start cycle already counts as the first hold cycle, so the counter
   // is loaded pre-decremented: Div_Done lands on the DIV_LAT-th cycle.
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_LAT - 2);

   state_t           state;
   logic [CNT_W-1:0] div_cnt;
   logic             div_done_seen;

   logic             dh_any;
   logic             exc_pend;
   logic             div_go;
   logic             div_hold;
   logic             div_fin;
   logic             dh_stall;

   always_comb begin
      dh_any   = bus.ID_EX_DH_Stall | bus.ID_MEM1_DH_Stall | bus.ID_MEM2_DH_Stall;
      exc_pend = (state == S_EXC) | bus.MEM_Exception;
      div_go   = (state == S_RUN) & bus.EXE_DivStart & ~div_done_seen;
      div_hold = div_go | ((state == S_DIV) & (div_cnt != '0));
      div_fin  = (state == S_DIV) & (div_cnt == '0);
      dh_stall = resetn & ~exc_pend & ~bus.Dcache_Busy & ~div_hold
                 & ~bus.EXE_PredFail & dh_any;
   end

   always_comb begin
      bus.PC_Wr        = 1'b1;
      bus.ID_Wr        = 1'b1;
      bus.EXE_Wr       = 1'b1;
      bus.MEM_Wr       = 1'b1;
      bus.MEM2_Wr      = 1'b1;
      bus.WB_Wr        = 1'b1;
      bus.ID_Flush     = 1'b0;
      bus.EXE_Flush    = 1'b0;
      bus.MEM_Flush    = 1'b0;
      bus.MEM2_Flush   = 1'b0;
      bus.Div_Done     = 1'b0;
      bus.Div_Abort    = 1'b0;
      bus.Exc_Redirect = 1'b0;

      if (!resetn) begin
         bus.PC_Wr      = 1'b0;
         bus.ID_Wr      = 1'b0;
         bus.EXE_Wr     = 1'b0;
         bus.MEM_Wr     = 1'b0;
         bus.MEM2_Wr    = 1'b0;
         bus.WB_Wr      = 1'b0;
         bus.ID_Flush   = 1'b1;
         bus.EXE_Flush  = 1'b1;
         bus.MEM_Flush  = 1'b1;
         bus.MEM2_Flush = 1'b1;
      end else if (exc_pend) begin
         bus.Div_Abort = (state == S_DIV);
         if (bus.Dcache_Busy) begin
            bus.PC_Wr   = 1'b0;
            bus.ID_Wr   = 1'b0;
            bus.EXE_Wr  = 1'b0;
            bus.MEM_Wr  = 1'b0;
            bus.MEM2_Wr = 1'b0;
            bus.WB_Wr   = 1'b0;
         end else begin
            bus.ID_Flush     = 1'b1;
            bus.EXE_Flush    = 1'b1;
            bus.MEM_Flush    = 1'b1;
            bus.MEM2_Flush   = 1'b1;
            bus.Exc_Redirect = 1'b1;
         end
      end else if (bus.Dcache_Busy) begin
         bus.PC_Wr   = 1'b0;
         bus.ID_Wr   = 1'b0;
         bus.EXE_Wr  = 1'b0;
         bus.MEM_Wr  = 1'b0;
         bus.MEM2_Wr = 1'b0;
         bus.WB_Wr   = 1'b0;
      end else if (div_hold) begin
         bus.PC_Wr     = 1'b0;
         bus.ID_Wr     = 1'b0;
         bus.EXE_Wr    = 1'b0;
         bus.MEM_Flush = 1'b1;
      end else begin
         bus.Div_Done = div_fin;
         // A mispredict squashes the wrong-path ID, so its hazards and fetch stalls are moot.
         if (bus.EXE_PredFail) begin
            bus.ID_Flush  = 1'b1;
            bus.EXE_Flush = 1'b1;
            bus.ID_Wr     = ~bus.Icache_Busy;
         end else if (dh_any) begin
            bus.PC_Wr     = 1'b0;
            bus.ID_Wr     = 1'b0;
            bus.EXE_Flush = 1'b1;
         end else if (bus.Icache_Busy) begin
            bus.PC_Wr    = 1'b0;
            bus.ID_Flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= S_RUN;
         div_cnt       <= '0;
         div_done_seen <= 1'b0;
      end else if (exc_pend) begin
         if (bus.Dcache_Busy) begin
            state <= S_EXC;
         end else begin
            state         <= S_RUN;
            div_cnt       <= '0;
            div_done_seen <= 1'b0;
         end
      end else if (!bus.Dcache_Busy) begin
         case (state)
            S_RUN: begin
               if (div_go) begin
                  div_cnt <= CNT_START;
                  state   <= S_DIV;
               end else if (!bus.EXE_DivStart) begin
                  div_done_seen <= 1'b0;
               end
            end
            S_DIV: begin
               if (div_cnt == '0) begin
                  state         <= S_RUN;
                  div_done_seen <= 1'b1;
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

`ifdef PIPE_STALL_PERF_EN
   logic [31:0] perf_dh;
   logic [31:0] perf_dc;
   logic [31:0] perf_div;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf_dh  <= '0;
         perf_dc  <= '0;
         perf_div <= '0;
      end else begin
         if (dh_stall)
            perf_dh <= perf_dh + 32'd1;
         if (bus.Dcache_Busy)
            perf_dc <= perf_dc + 32'd1;
         if (!exc_pend && !bus.Dcache_Busy && div_hold)
            perf_div <= perf_div + 32'd1;
      end
   end

   assign bus.Perf_DH_Cycles  = perf_dh;
   assign bus.Perf_Dc_Cycles  = perf_dc;
   assign bus.Perf_Div_Cycles = perf_div;
`else
   logic unused_dh_stall;
   assign unused_dh_stall = dh_stall;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table, multi-cycle corner sequences, then random stimulus against a cycle-count model.
module tb_pipe_stall_ctrl;
   localparam int DIV_LAT = 32;

   // output vector: {PC,ID,EXE,MEM,MEM2,WB}_Wr, {ID,EXE,MEM,MEM2}_Flush, Done, Abort, Redirect
   localparam logic [12:0] P_IDLE  = 13'b111111_0000_000;
   localparam logic [12:0] P_RST   = 13'b000000_1111_000;
   localparam logic [12:0] P_FRZ   = 13'b000000_0000_000;
   localparam logic [12:0] P_DH    = 13'b001111_0100_000;
   localparam logic [12:0] P_IC    = 13'b011111_1000_000;
   localparam logic [12:0] P_PF    = 13'b111111_1100_000;
   localparam logic [12:0] P_PFIC  = 13'b101111_1100_000;
   localparam logic [12:0] P_HOLD  = 13'b000111_0010_000;
   localparam logic [12:0] P_EXC   = 13'b111111_1111_001;
   localparam logic [12:0] P_EXCAB = 13'b111111_1111_011;
   localparam logic [12:0] P_DONE  = 13'b111111_0000_100;

   // input vector: {EX_DH, MEM1_DH, MEM2_DH, Icache, Dcache, DivStart, PredFail, Exception}
   localparam logic [7:0] I_NONE = 8'b0000_0000;
   localparam logic [7:0] I_M1DH = 8'b0100_0000;
   localparam logic [7:0] I_DC   = 8'b0000_1000;
   localparam logic [7:0] I_DIV  = 8'b0000_0100;
   localparam logic [7:0] I_EXC  = 8'b0000_0001;

   typedef struct {
      logic [7:0]  in;
      logic [12:0] exp;
      string       name;
   } vec_t;

   logic clk;
   logic resetn;
   logic [12:0] dut_o;
   int total;
   int bad;

   logic m_exc_wait;
   logic m_div_active;
   logic m_done_seen;
   int   m_div_elapsed;

   pipe_stall_ctrl_if bus();

   pipe_stall_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   assign dut_o = {bus.PC_Wr, bus.ID_Wr, bus.EXE_Wr, bus.MEM_Wr, bus.MEM2_Wr, bus.WB_Wr,
                   bus.ID_Flush, bus.EXE_Flush, bus.MEM_Flush, bus.MEM2_Flush,
                   bus.Div_Done, bus.Div_Abort, bus.Exc_Redirect};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [7:0] in, input logic rn);
      @(posedge clk);
      #1;
      resetn               = rn;
      bus.ID_EX_DH_Stall   = in[7];
      bus.ID_MEM1_DH_Stall = in[6];
      bus.ID_MEM2_DH_Stall = in[5];
      bus.Icache_Busy      = in[4];
      bus.Dcache_Busy      = in[3];
      bus.EXE_DivStart     = in[2];
      bus.EXE_PredFail     = in[1];
      bus.MEM_Exception    = in[0];
   endtask

   task automatic chk(input string name, input logic [12:0] exp);
      @(negedge clk);
      total++;
      if (dut_o !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, dut_o, exp);
      end
   endtask

   // Model tracks a divide as "hold cycles elapsed" and finishes on the DIV_LAT-th one.
   function automatic logic [12:0] model_out(input logic [7:0] in, input logic rn);
      logic [12:0] o;
      logic        starting;
      logic        final_c;
      if (!rn) return P_RST;
      if (m_exc_wait || in[0]) begin
         o = in[3] ? P_FRZ : P_EXC;
         o[1] = m_div_active;
         return o;
      end
      if (in[3]) return P_FRZ;
      starting = !m_div_active && in[2] && !m_done_seen;
      final_c  = m_div_active && (m_div_elapsed == DIV_LAT - 1);
      if (starting || (m_div_active && !final_c)) return P_HOLD;
      if (in[1])              o = in[4] ? P_PFIC : P_PF;
      else if (in[7:5] != 0)  o = P_DH;
      else if (in[4])         o = P_IC;
      else                    o = P_IDLE;
      o[2] = final_c;
      return o;
   endfunction

   task automatic model_step(input logic [7:0] in, input logic rn);
      if (!rn) begin
         m_exc_wait = 0; m_div_active = 0; m_done_seen = 0; m_div_elapsed = 0;
      end else if (m_exc_wait || in[0]) begin
         m_div_active = 0;
         if (in[3]) m_exc_wait = 1;
         else begin
            m_exc_wait  = 0;
            m_done_seen = 0;
         end
      end else if (!in[3]) begin
         if (m_div_active) begin
            if (m_div_elapsed == DIV_LAT - 1) begin
               m_div_active = 0;
               m_done_seen  = 1;
            end else m_div_elapsed++;
         end else if (in[2] && !m_done_seen) begin
            m_div_active  = 1;
            m_div_elapsed = 1;
         end else if (!in[2]) m_done_seen = 0;
      end
   endtask

   initial begin
      vec_t vecs[16];
      logic [7:0] rin;
      logic rrn;
      logic [12:0] rexp;

      vecs[0]  = '{8'b0000_0000, P_IDLE, "idle"};
      vecs[1]  = '{8'b1000_0000, P_DH,   "ex_dh"};
      vecs[2]  = '{8'b0010_0000, P_DH,   "mem2_dh"};
      vecs[3]  = '{8'b0001_0000, P_IC,   "icache"};
      vecs[4]  = '{8'b1001_0000, P_DH,   "dh_over_ic"};
      vecs[5]  = '{8'b0000_0010, P_PF,   "predfail"};
      vecs[6]  = '{8'b1000_0010, P_PF,   "pf_over_dh"};
      vecs[7]  = '{8'b0001_0010, P_PFIC, "pf_with_ic"};
      vecs[8]  = '{8'b0000_1000, P_FRZ,  "dcache"};
      vecs[9]  = '{8'b1001_1010, P_FRZ,  "dc_over_all"};
      vecs[10] = '{8'b0000_0100, P_HOLD, "div_start"};
      vecs[11] = '{8'b1000_0110, P_HOLD, "div_over_pf_dh"};
      vecs[12] = '{8'b0000_0001, P_EXC,  "exception"};
      vecs[13] = '{8'b0000_1001, P_FRZ,  "exc_dc"};
      vecs[14] = '{8'b0000_0111, P_EXC,  "exc_over_div_pf"};
      vecs[15] = '{8'b0000_1100, P_FRZ,  "dc_over_div"};

      total = 0;
      bad   = 0;
      resetn = 1'b0;
      bus.ID_EX_DH_Stall = 0; bus.ID_MEM1_DH_Stall = 0; bus.ID_MEM2_DH_Stall = 0;
      bus.Icache_Busy = 0; bus.Dcache_Busy = 0; bus.EXE_DivStart = 0;
      bus.EXE_PredFail = 0; bus.MEM_Exception = 0;

      for (int c = 0; c < 3; c++) begin
         drive(I_NONE, 1'b0);
         chk($sformatf("rst_hold%0d", c), P_RST);
      end
      drive(I_NONE, 1'b1);
      chk("rst_release", P_IDLE);

      for (int v = 0; v < 16; v++) begin
         drive(I_NONE, 1'b0);
         chk("vec_rst", P_RST);
         drive(vecs[v].in, 1'b1);
         chk(vecs[v].name, vecs[v].exp);
      end
      drive(I_NONE, 1'b0);
      chk("vec_rst", P_RST);

      drive(I_NONE, 1'b1);
      chk("pre_dh_idle", P_IDLE);
      for (int c = 0; c < 2; c++) begin
         drive(I_M1DH, 1'b1);
         chk($sformatf("mem1_dh c%0d", c), P_DH);
      end
      drive(I_NONE, 1'b1);
      chk("post_dh_idle", P_IDLE);

      for (int c = 1; c <= DIV_LAT + 1; c++) begin
         drive(I_DIV, 1'b1);
         if (c < DIV_LAT)       chk($sformatf("div c%0d", c), P_HOLD);
         else if (c == DIV_LAT) chk("div_done", P_DONE);
         else                   chk("div_no_restart", P_IDLE);
      end
      drive(I_NONE, 1'b1);
      chk("div_clear", P_IDLE);

      for (int c = 1; c <= 37; c++) begin
         drive((c >= 10 && c <= 14) ? (I_DIV | I_DC) : I_DIV, 1'b1);
         if (c >= 10 && c <= 14) chk($sformatf("divdc frz c%0d", c), P_FRZ);
         else if (c < 37)        chk($sformatf("divdc hold c%0d", c), P_HOLD);
         else                    chk("divdc_done37", P_DONE);
      end
      drive(I_NONE, 1'b1);
      chk("divdc_after", P_IDLE);

      for (int c = 1; c <= 3; c++) begin
         drive(I_EXC | I_DC, 1'b1);
         chk($sformatf("excdc frz c%0d", c), P_FRZ);
      end
      drive(I_NONE, 1'b1);
      chk("excdc_redirect", P_EXC);
      drive(I_NONE, 1'b1);
      chk("excdc_after", P_IDLE);

      for (int c = 1; c <= 4; c++) begin
         drive(I_DIV, 1'b1);
         chk($sformatf("divexc hold c%0d", c), P_HOLD);
      end
      drive(I_DIV | I_EXC, 1'b1);
      chk("divexc_abort", P_EXCAB);
      drive(I_NONE, 1'b1);
      chk("divexc_after", P_IDLE);

      for (int c = 1; c <= 3; c++) begin
         drive(I_DIV, 1'b1);
         chk($sformatf("divrst hold c%0d", c), P_HOLD);
      end
      drive(I_DIV, 1'b0);
      chk("divrst_in_reset", P_RST);
      drive(I_NONE, 1'b1);
      chk("divrst_after", P_IDLE);

      model_step(I_NONE, 1'b0);
      for (int n = 0; n < 3000; n++) begin
         rin[7] = ($urandom_range(0, 9) == 0);
         rin[6] = ($urandom_range(0, 9) == 0);
         rin[5] = ($urandom_range(0, 9) == 0);
         rin[4] = ($urandom_range(0, 6) == 0);
         rin[3] = ($urandom_range(0, 6) == 0);
         rin[2] = ($urandom_range(0, 1) == 0);
         rin[1] = ($urandom_range(0, 9) == 0);
         rin[0] = ($urandom_range(0, 39) == 0);
         rrn    = ($urandom_range(0, 199) != 0);
         drive(rin, rrn);
         rexp = model_out(rin, rrn);
         chk($sformatf("rand n%0d in=%b rn=%b", n, rin, rrn), rexp);
         model_step(rin, rrn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
